// File: rtl/axis_fifo_pkg.sv
// Shared helpers for axis_fifo: pointer width and binary/gray conversions.
// Latency: n/a (constant functions and combinational helpers only).
// Backpressure: n/a.
package axis_fifo_pkg;

    // Conversions run on a fixed 32-bit carrier. Callers zero-extend a
    // narrower pointer in and truncate the result back, which is exact for
    // both directions because the extra high bits stay zero.
    localparam int PTR_MAX_W = 32;
    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Pointer width is address bits plus one wrap bit, which separates
    // full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Pointer synchroniser: WIDTH-bit flop chain of DEPTH stages, reset to 0.
// Latency: DEPTH clock edges from i_dat to o_dat.
// Backpressure: none, samples every edge.
// Ports: i_clk/i_rst_n clock and async active-low reset, i_dat in, o_dat out.
module axis_fifo_sync #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/axis_fifo.sv
// First-word-fall-through FIFO for AXI4-Stream beats stored as opaque words.
// Latency: a word written at edge N shows on valid_o/data_o after edge N+SYNC_DEPTH.
// Backpressure: ready_i drops when full; a relieving pop raises it SYNC_DEPTH edges later.
// Ports: aclk/aresetn clock and async active-low reset; data_i/valid_i/ready_i
//        upstream side; data_o/valid_o/ready_o downstream side.
// Option: define AXIS_FIFO_LEVEL_EN to add output level (write-side fill count).
module axis_fifo
    import axis_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [FIFO_WIDTH-1:0]      data_i,
    input  logic                       valid_i,
    output logic                       ready_i,
    output logic [FIFO_WIDTH-1:0]      data_o,
    output logic                       valid_o,
`ifdef AXIS_FIFO_LEVEL_EN
    output logic [$clog2(FIFO_DEPTH):0] level,
`endif
    input  logic                       ready_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = ptr_width(FIFO_DEPTH);
    // Full when the write gray pointer equals the synced read gray pointer
    // with its top two bits inverted (one full lap ahead).
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (AW - 1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_gray;
    logic [PW-1:0] r_rd_gray;
    logic [PW-1:0] w_wr_gray_s;
    logic [PW-1:0] w_rd_gray_s;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic          r_run;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // Flags compare against delayed copies of the far pointer, so they can
    // only be late to clear, never early: no overflow or underflow.
    assign w_full  = (r_wr_gray == (w_rd_gray_s ^ FULL_MASK));
    assign w_empty = (r_rd_gray == w_wr_gray_s);

    // r_run holds ready_i low until the first edge after reset release.
    assign ready_i = r_run && !w_full;
    assign valid_o = !w_empty;

    assign w_push       = valid_i && ready_i;
    assign w_pop        = valid_o && ready_o;
    assign w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_run     <= 1'b0;
            r_wr_ptr  <= '0;
            r_wr_gray <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_push) begin
                r_wr_ptr  <= w_wr_ptr_nxt;
                r_wr_gray <= PW'(bin2gray(ptr_word_t'(w_wr_ptr_nxt)));
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_ptr  <= '0;
            r_rd_gray <= '0;
        end else if (w_pop) begin
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_rd_gray <= PW'(bin2gray(ptr_word_t'(w_rd_ptr_nxt)));
        end
    end

    // Storage is not reset; reset only discards it by clearing pointers.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_i;
        end
    end

    // Head word is read combinationally; it only moves on a pop, so it is
    // stable while valid_o && !ready_o.
    assign data_o = r_mem[r_rd_ptr[AW-1:0]];

    axis_fifo_sync #(
        .WIDTH (PW),
        .DEPTH (SYNC_DEPTH)
    ) u_wr2rd_sync (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_dat   (r_wr_gray),
        .o_dat   (w_wr_gray_s)
    );

    axis_fifo_sync #(
        .WIDTH (PW),
        .DEPTH (SYNC_DEPTH)
    ) u_rd2wr_sync (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_dat   (r_rd_gray),
        .o_dat   (w_rd_gray_s)
    );

`ifdef AXIS_FIFO_LEVEL_EN
    assign level = r_wr_ptr - PW'(gray2bin(ptr_word_t'(w_rd_gray_s)));
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// Directed and randomised-stream bench for axis_fifo at default parameters.
module tb_axis_fifo;

    logic       aclk;
    logic       aresetn;
    logic [9:0] data_i;
    logic       valid_i;
    logic       ready_i;
    logic [9:0] data_o;
    logic       valid_o;
    logic       ready_o;
`ifdef AXIS_FIFO_LEVEL_EN
    logic [3:0] level;
`endif

    int checks;
    int errors;

    axis_fifo #(
        .FIFO_WIDTH (10),
        .FIFO_DEPTH (8),
        .SYNC_DEPTH (2)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_i (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o),
`ifdef AXIS_FIFO_LEVEL_EN
        .level   (level),
`endif
        .ready_o (ready_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_o = 1'b0;
        repeat (3) tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_o got %b want 0", valid_o);
        end
        checks++;
        if (ready_i !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_i got %b want 0", ready_i);
        end
        #2 aresetn = 1'b1;
        #1;
        checks++;
        if (ready_i !== 1'b0) begin
            errors++;
            $display("FAIL release_ready_i_before_edge got %b want 0", ready_i);
        end
        tick();
        checks++;
        if (ready_i !== 1'b1) begin
            errors++;
            $display("FAIL release_ready_i_first_edge got %b want 1", ready_i);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL release_valid_o got %b want 0", valid_o);
        end
    endtask

    task automatic test_single();
        data_i  = 10'h2A5;
        valid_i = 1'b1;
        ready_o = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_valid_edge1 got %b want 0", valid_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_valid_edge2 got %b want 0", valid_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 10'h2A5) begin
            errors++;
            $display("FAIL single_visible got valid=%b data=%h want valid=1 data=2a5", valid_o, data_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_popped got valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_fill();
        int accepted;
        int next_word;
        accepted  = 0;
        next_word = 1;
        ready_o   = 1'b0;
        for (int c = 0; c < 14; c++) begin
            logic take;
            data_i  = 10'(next_word);
            valid_i = 1'b1;
            take    = ready_i;
            tick();
            if (take) begin
                accepted++;
                if (next_word < 9) next_word++;
            end
        end
        checks++;
        if (accepted !== 8) begin
            errors++;
            $display("FAIL fill_accepted got %0d want 8", accepted);
        end
        checks++;
        if (ready_i !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready_i got %b want 0", ready_i);
        end
        checks++;
        if (valid_o !== 1'b1 || data_o !== 10'h001) begin
            errors++;
            $display("FAIL fill_head got valid=%b data=%h want valid=1 data=001", valid_o, data_o);
        end
    endtask

    task automatic test_drain();
        int n_out;
        int first_rdy;
        n_out     = 0;
        first_rdy = -1;
        ready_o   = 1'b1;
        for (int c = 0; c < 40 && n_out < 9; c++) begin
            logic take;
            if (valid_o) begin
                checks++;
                if (data_o !== 10'(n_out + 1)) begin
                    errors++;
                    $display("FAIL drain_word%0d got %h want %h", n_out, data_o, 10'(n_out + 1));
                end
                n_out++;
            end
            if (ready_i && first_rdy < 0) first_rdy = c;
            take = valid_i && ready_i;
            tick();
            if (take) valid_i = 1'b0;
        end
        checks++;
        if (n_out !== 9) begin
            errors++;
            $display("FAIL drain_count got %0d want 9", n_out);
        end
        // c=0 is before the first pop edge, so two edges later is c=3.
        checks++;
        if (first_rdy !== 3) begin
            errors++;
            $display("FAIL drain_ready_return got sample %0d want 3", first_rdy);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_stream();
        logic [9:0] words [200];
        int pkt_left;
        int in_idx;
        int out_idx;
        int bad;
        logic held_vld;
        logic [9:0] held_dat;
        pkt_left = 0;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] d;
            if (pkt_left == 0) pkt_left = $urandom_range(16, 1);
            d = 8'($urandom_range(255, 0));
            words[i] = {1'b1, (pkt_left == 1), d};
            pkt_left--;
        end
        in_idx   = 0;
        out_idx  = 0;
        bad      = 0;
        held_vld = 1'b0;
        held_dat = '0;
        valid_i  = 1'b0;
        for (int c = 0; c < 5000 && out_idx < 200; c++) begin
            logic take_in;
            if (held_vld) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== held_dat) begin
                    errors++;
                    $display("FAIL stream_hold got valid=%b data=%h want valid=1 data=%h", valid_o, data_o, held_dat);
                end
            end
            if (!valid_i && in_idx < 200 && $urandom_range(1, 0) == 1) begin
                valid_i = 1'b1;
                data_i  = words[in_idx];
            end
            ready_o = ($urandom_range(1, 0) == 1);
            take_in = valid_i && ready_i;
            held_vld = valid_o && !ready_o;
            held_dat = data_o;
            if (valid_o && ready_o) begin
                checks++;
                if (out_idx >= in_idx || data_o !== words[out_idx]) begin
                    errors++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL stream_word%0d got %h want %h", out_idx, data_o, words[out_idx]);
                end
                out_idx++;
            end
            tick();
            if (take_in) begin
                in_idx++;
                valid_i = 1'b0;
            end
        end
        valid_i = 1'b0;
        ready_o = 1'b1;
        checks++;
        if (out_idx !== 200) begin
            errors++;
            $display("FAIL stream_count got %0d want 200", out_idx);
        end
        repeat (4) tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_no_extra got valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        ready_o = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_i  = 10'h100 + 10'(i);
            valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        repeat (2) tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 10'h100) begin
            errors++;
            $display("FAIL midrst_before got valid=%b data=%h want valid=1 data=100", valid_o, data_o);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || ready_i !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got valid=%b ready=%b want 0 0", valid_o, ready_i);
        end
        tick();
        aresetn = 1'b1;
        tick();
        checks++;
        if (valid_o !== 1'b0 || ready_i !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after got valid=%b ready=%b want 0 1", valid_o, ready_i);
        end
        data_i  = 10'h3FF;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        waited  = 0;
        while (!valid_o && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (valid_o !== 1'b1 || data_o !== 10'h3FF) begin
            errors++;
            $display("FAIL midrst_new_word got valid=%b data=%h want valid=1 data=3ff", valid_o, data_o);
        end
        ready_o = 1'b1;
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_empty got valid=%b want 0", valid_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
